// File: rtl/core_ibex_fcov_stall_mon.sv
// Stall monitor: tracks run lengths of ID-stage stalls per cause and reports terminated runs.
// Optional per-cause longest-run table is built when FCOV_STALL_MAX_EN is defined.
module core_ibex_fcov_stall_mon #(
   parameter int unsigned NumCauses = 5,
   parameter int unsigned CntW      = 8,
   localparam int unsigned CauseW   = (NumCauses > 1) ? $clog2(NumCauses) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      instr_valid_i,
   input  logic [NumCauses-1:0]      stall_i,
   input  logic                      clear_i,
   output logic                      stall_active_o,
   output logic [CauseW-1:0]         stall_cause_o,
   output logic [CntW-1:0]           run_len_o,
   output logic                      run_end_o,
   output logic [CntW-1:0]           run_end_len_o,
   output logic [CauseW-1:0]         run_end_cause_o,
   output logic                      cause_change_o,
   output logic [NumCauses*CntW-1:0] max_run_o,
   output logic                      sat_o
);

   localparam logic [CntW-1:0] RunMax = '1;

   typedef enum logic {
      Idle  = 1'b0,
      Stall = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   run_len_q, run_len_d;
   logic [CauseW-1:0] cur_cause_q, cur_cause_d;
   logic [CauseW-1:0] cause;
   logic              stall_any;
   logic              term, chg;
   logic              run_end_q, cause_change_q, sat_q;
   logic [CntW-1:0]   run_end_len_q;
   logic [CauseW-1:0] run_end_cause_q;

   assign stall_any = instr_valid_i & (|stall_i);

   // Lowest set stall bit wins
   always_comb begin
      cause = '0;
      for (int i = int'(NumCauses) - 1; i >= 0; i--) begin
         if (stall_i[i]) cause = CauseW'(i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= Idle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         Idle:    if (stall_any)  state_d = Stall;
         Stall:   if (!stall_any) state_d = Idle;
         default: state_d = Idle;
      endcase
   end

   // Run counter / cause next values and termination detection
   always_comb begin
      run_len_d   = '0;
      cur_cause_d = '0;
      term        = 1'b0;
      chg         = 1'b0;
      case (state_q)
         Idle: begin
            if (stall_any) begin
               run_len_d   = CntW'(1);
               cur_cause_d = cause;
            end
         end
         Stall: begin
            if (!stall_any) begin
               term = 1'b1;
            end else if (cause != cur_cause_q) begin
               term        = 1'b1;
               chg         = 1'b1;
               run_len_d   = CntW'(1);
               cur_cause_d = cause;
            end else begin
               run_len_d   = (run_len_q == RunMax) ? RunMax : run_len_q + CntW'(1);
               cur_cause_d = cur_cause_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_len_q       <= '0;
         cur_cause_q     <= '0;
         run_end_q       <= 1'b0;
         cause_change_q  <= 1'b0;
         run_end_len_q   <= '0;
         run_end_cause_q <= '0;
         sat_q           <= 1'b0;
      end else begin
         run_len_q      <= run_len_d;
         cur_cause_q    <= cur_cause_d;
         run_end_q      <= term;
         cause_change_q <= chg;
         if (term) begin
            run_end_len_q   <= run_len_q;
            run_end_cause_q <= cur_cause_q;
         end
         if (clear_i)                  sat_q <= 1'b0;
         else if (run_len_d == RunMax) sat_q <= 1'b1;
      end
   end

`ifdef FCOV_STALL_MAX_EN
   logic [CntW-1:0] max_q [NumCauses];

   // Longest terminated run per cause; clear wins over a same-cycle update
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < int'(NumCauses); c++) max_q[c] <= '0;
      end else begin
         for (int c = 0; c < int'(NumCauses); c++) begin
            if (clear_i) begin
               max_q[c] <= '0;
            end else if (term && (cur_cause_q == CauseW'(c)) && (run_len_q > max_q[c])) begin
               max_q[c] <= run_len_q;
            end
         end
      end
   end

   always_comb begin
      max_run_o = '0;
      for (int c = 0; c < int'(NumCauses); c++) begin
         max_run_o[c*CntW +: CntW] = max_q[c];
      end
   end
`else
   assign max_run_o = '0;
`endif

   assign stall_active_o  = (state_q == Stall);
   assign stall_cause_o   = cur_cause_q;
   assign run_len_o       = run_len_q;
   assign run_end_o       = run_end_q;
   assign run_end_len_o   = run_end_len_q;
   assign run_end_cause_o = run_end_cause_q;
   assign cause_change_o  = cause_change_q;
   assign sat_o           = sat_q;

endmodule

// File: doc/core_ibex_fcov_stall_mon.md
CORE_IBEX_FCOV_STALL_MON -- requirements
Module: core_ibex_fcov_stall_mon

Interface
REQ-001 Parameter NumCauses, default 5, number of stall-cause inputs; legal range 1..16.
REQ-002 Parameter CntW, default 8, run-length counter width in bits; legal range 2..16.
REQ-003 Port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port rst_ni, input, 1, reset; asynchronous and active-low.
REQ-005 Port instr_valid_i, input, 1, the ID stage holds a valid instruction.
REQ-006 Port stall_i, input, NumCauses, per-cause stall flags; bit 0 has highest priority.
REQ-007 Port clear_i, input, 1, synchronous clear of the statistics (max table, sticky saturation).
REQ-008 Port stall_active_o, input-derived output, 1, monitor is in STALL state.
REQ-009 Port stall_cause_o, output, $clog2(NumCauses) (min 1), cause of the current run.
REQ-010 Port run_len_o, output, CntW, length in cycles of the current run.
REQ-011 Port run_end_o, output, 1, one-cycle pulse: a run has just terminated.
REQ-012 Port run_end_len_o / run_end_cause_o, output, CntW / cause width, length and cause of the last terminated run.
REQ-013 Port cause_change_o, output, 1, one-cycle pulse: a run ended by a cause switch with no idle cycle between.
REQ-014 Port max_run_o, output, NumCauses*CntW, per-cause longest terminated run; cause c at bits [c*CntW +: CntW].
REQ-015 Port sat_o, output, 1, sticky: some run counter reached all-ones.

Function
REQ-016 stall_any = instr_valid_i AND (OR of stall_i); cause = lowest set index of stall_i.
REQ-017 FSM states IDLE and STALL; IDLE->STALL on stall_any, loading run_len=1 and cur_cause=cause.
REQ-018 In STALL, stall_any with cause==cur_cause: run_len increments by 1, saturating at 2^CntW-1.
REQ-019 In STALL, stall_any with cause!=cur_cause: terminate old run, restart with run_len=1 and new cur_cause, remain in STALL, and assert cause_change_o.
REQ-020 In STALL, not stall_any (including instr_valid_i low with stall bits set): terminate run and go to IDLE.
REQ-021 On termination, run_end_o, run_end_len_o and run_end_cause_o update in the next cycle (1-cycle latency); cause_change_o is aligned with the same run_end_o pulse.
REQ-022 run_end_len_o and run_end_cause_o hold their values until the next termination.
REQ-023 In IDLE, run_len_o=0, stall_cause_o=0, and stall_active_o=0.
REQ-024 sat_o sets on the cycle run_len reaches 2^CntW-1 and stays set until clear_i or reset.
REQ-025 On termination, max_run_o[cause] is updated to the max of its old value and the terminated length, visible together with run_end_o.
REQ-026 clear_i zeroes max_run_o and sat_o next cycle, with priority over a same-cycle max update or saturation set; run state is not affected.

Reset
REQ-027 While rst_ni is low: state=IDLE and every output is 0, including run_end_len_o, run_end_cause_o, max_run_o and sat_o.
REQ-028 Reset asserted mid-run discards the run without a run_end_o pulse after release.

Configuration
REQ-029 Macro FCOV_STALL_MAX_EN defined: the per-cause max table (REQ-025, REQ-026 max part) is built.
REQ-030 Macro FCOV_STALL_MAX_EN undefined: no max registers are built, max_run_o is tied to 0, and all other behaviour is unchanged.

Verification (NumCauses=5, CntW=4, macro defined)
REQ-031 instr_valid_i=1, stall_i=5'b00100 for 3 cycles then 0 -> run_len_o=1,2,3; next cycle run_end_o=1, run_end_len_o=3, run_end_cause_o=2, max_run_o[2]=3.
REQ-032 stall_i=5'b00010 for 2 cycles then 5'b00001 for 1 cycle then 0 -> two run_end_o pulses (len2 cause1 with cause_change_o=1; then len1 cause0 with cause_change_o=0).
REQ-033 stall_i=5'b00001 held 20 cycles -> run_len_o sticks at 15, sat_o=1; at end run_end_len_o=15.
REQ-034 stall_i=5'b01000 with instr_valid_i=0 -> state stays IDLE and no pulses occur.
REQ-035 clear_i=1 in the same cycle as a termination of len 4 -> max_run_o all 0 and sat_o=0 next cycle, while run_end_o still pulses with len 4.
REQ-036 rst_ni low during a 5-cycle run -> all outputs 0 immediately; after release with stall_i=0, no run_end_o pulse.
